// File: rtl/fpu_sched_if.sv
// Bundle between the fpu scheduler, its two requesters and the shared fpu.
// slave: scheduler side; master: requesters plus fpu side.
interface fpu_sched_if;
    logic        r0_req;
    logic        r0_sub;
    logic [22:0] r0_a;
    logic [22:0] r0_b;
    logic        r0_ack;
    logic        r1_req;
    logic        r1_sub;
    logic [22:0] r1_a;
    logic [22:0] r1_b;
    logic        r1_ack;
    logic        fpu_add;
    logic        fpu_sub;
    logic [22:0] fpu_op1;
    logic [22:0] fpu_op2;
    logic        fpu_rst;
    logic        fpu_idle;
    logic [22:0] fpu_res;
    logic        res_valid;
    logic [22:0] res;
    logic        res_owner;
    logic        res_err;
    logic        busy;

    modport slave (
        input  r0_req, r0_sub, r0_a, r0_b,
        input  r1_req, r1_sub, r1_a, r1_b,
        input  fpu_idle, fpu_res,
        output r0_ack, r1_ack,
        output fpu_add, fpu_sub, fpu_op1, fpu_op2, fpu_rst,
        output res_valid, res, res_owner, res_err, busy
    );

    modport master (
        output r0_req, r0_sub, r0_a, r0_b,
        output r1_req, r1_sub, r1_a, r1_b,
        output fpu_idle, fpu_res,
        input  r0_ack, r1_ack,
        input  fpu_add, fpu_sub, fpu_op1, fpu_op2, fpu_rst,
        input  res_valid, res, res_owner, res_err, busy
    );
endinterface

// File: rtl/fpu_sched.sv
// Round-robin scheduler sharing one fpu add/sub unit between two requesters.
// Ports: clk, reset (async, active-high), bus (fpu_sched_if.slave):
//   r0_*/r1_* request/ack, fpu_* drive and status, res* tagged result, busy.
module fpu_sched #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input logic       clk,
    input logic       reset,
    fpu_sched_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] wd;
    logic          wd_hit;
    logic          last;
    logic          owner;
    logic          op_sub;
    logic          grant;
    logic          pick1;
    logic          start;
    logic          done;
    logic          abort;
    logic          waiting;

    assign wd_hit = (wd == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:
                if (bus.r0_req || bus.r1_req) state_n = ISSUE;
            ISSUE:
                if (bus.fpu_idle) state_n = WAIT_BUSY;
            WAIT_BUSY:
                if (wd_hit)             state_n = RESP;
                else if (!bus.fpu_idle) state_n = WAIT_DONE;
            WAIT_DONE:
                if (bus.fpu_idle || wd_hit) state_n = RESP;
            RESP:
                state_n = IDLE;
            default:
                state_n = IDLE;
        endcase
    end

    // last == 1 means r1 was served last, so r0 wins a tie
    always_comb begin
        grant   = 1'b0;
        pick1   = 1'b0;
        start   = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        waiting = 1'b0;
        unique case (state)
            IDLE: begin
                grant = bus.r0_req | bus.r1_req;
                pick1 = bus.r1_req & (~bus.r0_req | ~last);
            end
            ISSUE:
                start = bus.fpu_idle;
            WAIT_BUSY: begin
                waiting = 1'b1;
                abort   = wd_hit;
            end
            WAIT_DONE: begin
                waiting = 1'b1;
                done    = bus.fpu_idle;
                abort   = wd_hit & ~bus.fpu_idle;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.r0_ack    <= 1'b0;
            bus.r1_ack    <= 1'b0;
            bus.fpu_add   <= 1'b0;
            bus.fpu_sub   <= 1'b0;
            bus.fpu_rst   <= 1'b0;
            bus.fpu_op1   <= '0;
            bus.fpu_op2   <= '0;
            bus.res_valid <= 1'b0;
            bus.res       <= '0;
            bus.res_owner <= 1'b0;
            bus.res_err   <= 1'b0;
            bus.busy      <= 1'b0;
            wd            <= '0;
            last          <= 1'b1;
            owner         <= 1'b0;
            op_sub        <= 1'b0;
        end else begin
            bus.r0_ack    <= grant & ~pick1;
            bus.r1_ack    <= grant & pick1;
            bus.fpu_add   <= start & ~op_sub;
            bus.fpu_sub   <= start & op_sub;
            bus.fpu_rst   <= abort;
            bus.res_valid <= done | abort;
            bus.busy      <= (state_n != IDLE);
            if (grant) begin
                owner       <= pick1;
                op_sub      <= pick1 ? bus.r1_sub : bus.r0_sub;
                bus.fpu_op1 <= pick1 ? bus.r1_a : bus.r0_a;
                bus.fpu_op2 <= pick1 ? bus.r1_b : bus.r0_b;
            end
            if (start)        wd <= '0;
            else if (waiting) wd <= wd + 1'b1;
            if (done) begin
                bus.res       <= bus.fpu_res;
                bus.res_err   <= 1'b0;
                bus.res_owner <= owner;
            end else if (abort) begin
                bus.res       <= '0;
                bus.res_err   <= 1'b1;
                bus.res_owner <= owner;
            end
            if (state == RESP) last <= owner;
        end
    end

endmodule

// File: tb/tb_fpu_sched.sv
// Scoreboard bench for fpu_sched with a behavioural fpu and real-valued model.
// Ports driven through fpu_sched_if; clk and reset generated here.
module tb_fpu_sched;
    localparam int TIMEOUT = 64;
    localparam logic [22:0] ONE = 23'h004000;
    localparam logic [22:0] TWO = 23'h00C000;

    typedef struct {
        logic        owner;
        logic        sub;
        logic        err;
        logic [22:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fpu_sched_if bus ();

    fpu_sched #(.TIMEOUT(TIMEOUT), .CW(7)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t q[$];
    int   ack_log[$];
    bit   stub        = 1'b0;
    int   lat_min     = 1;
    int   lat_max     = 6;
    bit   tb_last     = 1'b1;
    bit   outstanding = 1'b0;
    bit   p_r0        = 1'b0;
    bit   p_r1        = 1'b0;
    int   n_add       = 0;
    int   n_sub       = 0;
    int   n_res       = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic real fdec(input logic [22:0] w);
        real v;
        int  e;
        e = $signed(w[21:15]);
        v = real'(w[14:0]) / 16384.0;
        if (e > 0) for (int i = 0; i < e; i++) v = v * 2.0;
        else       for (int i = 0; i < -e; i++) v = v / 2.0;
        return w[22] ? -v : v;
    endfunction

    function automatic logic [22:0] fenc(input real x);
        real        v;
        int         e;
        logic       s;
        logic [6:0] ev;
        logic [14:0] mv;
        if (x == 0.0) return '0;
        s = (x < 0.0);
        v = s ? -x : x;
        e = 0;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        ev = 7'(e);
        mv = 15'($rtoi(v * 16384.0));
        return {s, ev, mv};
    endfunction

    function automatic logic [22:0] fref(input logic [22:0] a, b, input logic sub);
        return fenc(sub ? fdec(a) - fdec(b) : fdec(a) + fdec(b));
    endfunction

    function automatic logic [22:0] rnd_word();
        int          e;
        logic [6:0]  ev;
        logic [13:0] m;
        e  = int'($urandom_range(12)) - 6;
        ev = 7'(e);
        m  = 14'($urandom);
        return {1'($urandom), ev, 1'b1, m};
    endfunction

    // behavioural fpu: idle drops after a start pulse, result after a latency
    initial begin : fpu_model
        bit          s_add, s_sub, s_rst, fbusy, fsub;
        int          cnt;
        logic [22:0] ra, rb;
        fbusy = 1'b0;
        fsub  = 1'b0;
        cnt   = 0;
        ra    = '0;
        rb    = '0;
        bus.fpu_idle = 1'b1;
        bus.fpu_res  = '0;
        forever begin
            @(negedge clk);
            s_add = bus.fpu_add;
            s_sub = bus.fpu_sub;
            s_rst = bus.fpu_rst;
            @(posedge clk);
            #1;
            if (reset || stub || s_rst) begin
                fbusy = 1'b0;
                bus.fpu_idle = 1'b1;
            end else if (s_add || s_sub) begin
                fbusy = 1'b1;
                fsub  = s_sub;
                ra    = bus.fpu_op1;
                rb    = bus.fpu_op2;
                cnt   = int'($urandom_range(lat_max, lat_min));
                bus.fpu_idle = 1'b0;
            end else if (fbusy) begin
                if (cnt == 0) begin
                    chk("op1_stable", 32'(bus.fpu_op1), 32'(ra));
                    chk("op2_stable", 32'(bus.fpu_op2), 32'(rb));
                    bus.fpu_res  = fref(bus.fpu_op1, bus.fpu_op2, fsub);
                    bus.fpu_idle = 1'b1;
                    fbusy = 1'b0;
                end else begin
                    cnt--;
                    bus.fpu_res = 23'($urandom);
                end
            end
        end
    end

    // monitor: pushes expectations on ack, pops and compares on res_valid
    initial begin : monitor
        exp_t e;
        bit   id, exp_id;
        forever begin
            @(negedge clk);
            if (reset) begin
                q.delete();
                tb_last     = 1'b1;
                outstanding = 1'b0;
                n_add       = 0;
                n_sub       = 0;
                p_r0        = 1'b0;
                p_r1        = 1'b0;
                continue;
            end
            if (bus.fpu_add) n_add++;
            if (bus.fpu_sub) n_sub++;
            if (bus.r0_ack || bus.r1_ack) begin
                id     = bus.r1_ack;
                exp_id = (p_r0 && p_r1) ? ~tb_last : p_r1;
                chk("ack_onehot", 32'(bus.r0_ack & bus.r1_ack), 0);
                chk("ack_while_busy", 32'(outstanding), 0);
                chk("grant_owner", 32'(id), 32'(exp_id));
                e.owner = id;
                e.sub   = id ? bus.r1_sub : bus.r0_sub;
                e.err   = stub;
                e.res   = stub ? 23'h0 :
                          (id ? fref(bus.r1_a, bus.r1_b, bus.r1_sub)
                              : fref(bus.r0_a, bus.r0_b, bus.r0_sub));
                q.push_back(e);
                ack_log.push_back(int'(id));
                outstanding = 1'b1;
            end
            if (bus.res_valid) begin
                if (q.size() == 0) begin
                    chk("res_unexpected", 32'(bus.res_valid), 0);
                end else begin
                    e = q.pop_front();
                    chk("res_value", 32'(bus.res), 32'(e.res));
                    chk("res_owner", 32'(bus.res_owner), 32'(e.owner));
                    chk("res_err", 32'(bus.res_err), 32'(e.err));
                    chk("fpu_rst", 32'(bus.fpu_rst), 32'(e.err));
                    chk("add_pulses", 32'(n_add), 32'(!e.sub));
                    chk("sub_pulses", 32'(n_sub), 32'(e.sub));
                    tb_last = e.owner;
                end
                n_add = 0;
                n_sub = 0;
                outstanding = 1'b0;
                n_res++;
            end
            p_r0 = bus.r0_req;
            p_r1 = bus.r1_req;
        end
    end

    task automatic do_req(input bit id, input bit sub,
                          input logic [22:0] a, input logic [22:0] b);
        bit got;
        @(posedge clk);
        #1;
        if (id) begin
            bus.r1_sub = sub; bus.r1_a = a; bus.r1_b = b; bus.r1_req = 1'b1;
        end else begin
            bus.r0_sub = sub; bus.r0_a = a; bus.r0_b = b; bus.r0_req = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            got = id ? bus.r1_ack : bus.r0_ack;
        end
        if (!got) chk(id ? "r1_ack_timeout" : "r0_ack_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (id) bus.r1_req = 1'b0;
        else    bus.r0_req = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            ok = (q.size() == 0) && !bus.busy;
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pulses", 32'({bus.r0_ack, bus.r1_ack, bus.fpu_add,
                               bus.fpu_sub, bus.fpu_rst, bus.res_valid}), 0);
        chk("rst_state", 32'({bus.busy, bus.res_owner, bus.res_err}), 0);
        chk("rst_res", 32'(bus.res), 0);
        chk("rst_ops", 32'(bus.fpu_op1 | bus.fpu_op2), 0);
        reset = 1'b0;
    endtask

    task automatic rand_worker(input bit id, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(4)) @(posedge clk);
            do_req(id, 1'($urandom), rnd_word(), rnd_word());
        end
    endtask

    initial begin : main
        int  base, d;
        bit  seen;
        bus.r0_req = 1'b0; bus.r0_sub = 1'b0; bus.r0_a = '0; bus.r0_b = '0;
        bus.r1_req = 1'b0; bus.r1_sub = 1'b0; bus.r1_a = '0; bus.r1_b = '0;
        do_reset();

        // r0 add 1.0+1.0: ack one cycle after req
        @(posedge clk);
        #1;
        bus.r0_sub = 1'b0; bus.r0_a = ONE; bus.r0_b = ONE; bus.r0_req = 1'b1;
        @(negedge clk);
        chk("ack_early", 32'(bus.r0_ack), 0);
        @(negedge clk);
        chk("ack_latency", 32'(bus.r0_ack), 1);
        @(posedge clk);
        #1;
        bus.r0_req = 1'b0;
        wait_drain();
        chk("add_1p1", 32'(bus.res), 32'(TWO));

        // r1 sub 2.0-1.0
        do_req(1'b1, 1'b1, TWO, ONE);
        wait_drain();
        chk("sub_2m1", 32'(bus.res), 32'(ONE));
        chk("sub_owner", 32'(bus.res_owner), 1);
        chk("sub_op1", 32'(bus.fpu_op1), 32'(TWO));

        // tie after reset favours r0, then r1
        do_reset();
        ack_log.delete();
        fork
            do_req(1'b0, 1'b0, rnd_word(), rnd_word());
            do_req(1'b1, 1'b0, rnd_word(), rnd_word());
        join
        wait_drain();
        chk("tie1_first", 32'(ack_log.size() > 0 ? ack_log[0] : 9), 0);
        chk("tie1_second", 32'(ack_log.size() > 1 ? ack_log[1] : 9), 1);

        // r0 served last, tie goes to r1
        do_req(1'b0, 1'b1, rnd_word(), rnd_word());
        wait_drain();
        ack_log.delete();
        fork
            do_req(1'b0, 1'b1, rnd_word(), rnd_word());
            do_req(1'b1, 1'b1, rnd_word(), rnd_word());
        join
        wait_drain();
        chk("tie2_first", 32'(ack_log.size() > 0 ? ack_log[0] : 9), 1);

        // r1 arrives while r0 in flight: held off until r0 responds
        ack_log.delete();
        lat_min = 8;
        lat_max = 8;
        fork
            do_req(1'b0, 1'b0, rnd_word(), rnd_word());
            begin
                repeat (3) @(posedge clk);
                do_req(1'b1, 1'b1, rnd_word(), rnd_word());
            end
        join
        wait_drain();
        chk("pending_order", 32'(ack_log.size() > 1 ? ack_log[1] : 9), 1);
        lat_min = 1;
        lat_max = 6;

        // random contention
        fork
            rand_worker(1'b0, 25);
            rand_worker(1'b1, 25);
        join
        wait_drain();

        // reset while waiting for completion
        lat_min = 20;
        lat_max = 20;
        do_req(1'b0, 1'b0, ONE, TWO);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = !bus.fpu_idle;
        end
        if (!seen) chk("fpu_busy_timeout", 0, 1);
        @(negedge clk);
        base  = n_res;
        reset = 1'b1;
        #1;
        chk("midrst_outs", 32'({bus.busy, bus.res_valid, bus.res_err,
                                bus.res_owner, bus.fpu_add}), 0);
        chk("midrst_res", 32'(bus.res | bus.fpu_op1 | bus.fpu_op2), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_novalid", 32'(bus.res_valid), 0);
        end
        reset = 1'b0;
        lat_min = 1;
        lat_max = 6;
        do_req(1'b1, 1'b0, TWO, TWO);
        wait_drain();
        chk("post_rst_done", 32'(n_res - base), 1);

        // watchdog with idle stuck high
        stub = 1'b1;
        do_req(1'b0, 1'b0, ONE, ONE);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.fpu_add;
        end
        if (!seen) chk("stub_start_timeout", 0, 1);
        d = 0;
        seen = 1'b0;
        while (!seen && d < 200) begin
            @(negedge clk);
            d++;
            seen = bus.res_valid;
        end
        chk("wd_cycles", 32'(d), 32'(TIMEOUT));
        chk("wd_res", 32'({bus.res_err, bus.res}), 32'({1'b1, 23'h0}));
        @(negedge clk);
        chk("wd_busy_clear", 32'(bus.busy), 0);
        stub = 1'b0;
        do_req(1'b1, 1'b1, TWO, ONE);
        wait_drain();
        chk("wd_recover", 32'({bus.res_err, bus.res}), 32'({1'b0, ONE}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
